// File: rtl/accel_bus_port_if.sv
// accel_bus_port_if: CPU-side and accelerator-side bus signals of the
// accelerator bus endpoint. The endpoint (accel_bus_port) connects through the
// slave modport. The driving side (CPU and accelerator) uses the master modport.
interface accel_bus_port_if;
    // CPU write path
    logic        cpu_wr_en;
    logic [15:0] cpu_wr_data;
    // CPU read path
    logic        cpu_rd_en;
    logic        cpu_rd_sel;
    logic [15:0] cpu_rd_data;
    logic        cpu_busy;
    // Command stream towards the accelerator
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_data;
    logic        cmd_first;
    logic        cmd_last;
    // Result stream from the accelerator
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;

    modport slave (
        input  cpu_wr_en, cpu_wr_data, cpu_rd_en, cpu_rd_sel, cmd_ready,
               res_valid, res_data,
        output cpu_rd_data, cpu_busy, cmd_valid, cmd_data, cmd_first,
               cmd_last, res_ready
    );

    modport master (
        output cpu_wr_en, cpu_wr_data, cpu_rd_en, cpu_rd_sel, cmd_ready,
               res_valid, res_data,
        input  cpu_rd_data, cpu_busy, cmd_valid, cmd_data, cmd_first,
               cmd_last, res_ready
    );
endinterface

// File: rtl/accel_bus_port.sv
// accel_bus_port: accelerator-side endpoint of the CPU accelerator bus.
// The command FIFO buffers CPU writes, which are framed into header/payload packets.
// The result FIFO buffers accelerator results, and its head word is returned
// combinationally on the CPU read path.
// Optional feature macro: ACCEL_BUS_STATUS_EN. When it is defined, the block adds
// the status word, cpu_rd_sel decoding and the ovf/unf sticky flags.
module accel_bus_port #(
    parameter int CMD_DEPTH = 8,
    parameter int RES_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    accel_bus_port_if.slave  bus
);
    localparam int CAW = $clog2(CMD_DEPTH);
    localparam int RAW = $clog2(RES_DEPTH);

    typedef enum logic [0:0] {ST_HDR = 1'b0, ST_PAY = 1'b1} state_e;

    // Storage and pointers. Each pointer carries an extra wrap bit.
    logic [15:0]  cmd_mem_q [CMD_DEPTH];
    logic [15:0]  res_mem_q [RES_DEPTH];
    logic [CAW:0] cmd_wp_q, cmd_wp_d, cmd_rp_q, cmd_rp_d, cmd_cnt_s;
    logic [RAW:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d, res_cnt_s;
    logic         cmd_full_s, cmd_empty_s, cmd_push_s, cmd_pop_s;
    logic         res_full_s, res_empty_s, res_push_s, res_pop_s;
    logic [15:0]  cmd_head_s, rd_data_s, status_s;
    logic         rd_sel_s, cmd_first_s, cmd_last_s;
    state_e       state_q, state_d;
    logic [11:0]  rem_q, rem_d;

`ifdef ACCEL_BUS_STATUS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    function automatic logic [3:0] sat4(input logic [15:0] cnt);
        return (cnt > 16'd15) ? 4'hF : cnt[3:0];
    endfunction

    assign rd_sel_s = bus.cpu_rd_sel;
    assign status_s = {cmd_full_s, res_empty_s, ovf_q, unf_q, 4'h0,
                       sat4(16'(cmd_cnt_s)), sat4(16'(res_cnt_s))};
`else
    logic unused_rd_sel_s;
    assign unused_rd_sel_s = bus.cpu_rd_sel;
    assign rd_sel_s        = 1'b0;
    assign status_s        = 16'h0000;
`endif

    assign cmd_cnt_s   = cmd_wp_q - cmd_rp_q;
    assign res_cnt_s   = res_wp_q - res_rp_q;
    assign cmd_full_s  = (cmd_cnt_s == (CAW+1)'(CMD_DEPTH));
    assign cmd_empty_s = (cmd_cnt_s == (CAW+1)'(0));
    assign res_full_s  = (res_cnt_s == (RAW+1)'(RES_DEPTH));
    assign res_empty_s = (res_cnt_s == (RAW+1)'(0));
    assign cmd_head_s  = cmd_mem_q[cmd_rp_q[CAW-1:0]];

    // Handshake decode and pointer advance. Fullness and emptiness come from the pre-edge pointers.
    always_comb begin
        cmd_push_s = bus.cpu_wr_en & ~cmd_full_s;
        cmd_pop_s  = ~cmd_empty_s & bus.cmd_ready;
        res_push_s = bus.res_valid & ~res_full_s;
        res_pop_s  = bus.cpu_rd_en & ~rd_sel_s & ~res_empty_s;
        cmd_wp_d   = cmd_push_s ? cmd_wp_q + (CAW+1)'(1) : cmd_wp_q;
        cmd_rp_d   = cmd_pop_s  ? cmd_rp_q + (CAW+1)'(1) : cmd_rp_q;
        res_wp_d   = res_push_s ? res_wp_q + (RAW+1)'(1) : res_wp_q;
        res_rp_d   = res_pop_s  ? res_rp_q + (RAW+1)'(1) : res_rp_q;
    end

    // Framing FSM next state, plus first/last flags for the word at the FIFO head.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        cmd_first_s = 1'b0;
        cmd_last_s  = 1'b0;
        case (state_q)
            ST_HDR: begin
                cmd_first_s = 1'b1;
                cmd_last_s  = ~cmd_empty_s & (cmd_head_s[11:0] == 12'd0);
                if (cmd_pop_s && (cmd_head_s[11:0] != 12'd0)) begin
                    rem_d   = cmd_head_s[11:0];
                    state_d = ST_PAY;
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_PAY: begin
                cmd_last_s = ~cmd_empty_s & (rem_q == 12'd1);
                if (cmd_pop_s) begin
                    rem_d   = rem_q - 12'd1;
                    state_d = (rem_q == 12'd1) ? ST_HDR : ST_PAY;
                end else begin
                    state_d = ST_PAY;
                end
            end
            default: begin
                state_d = ST_HDR;
                rem_d   = 12'd0;
            end
        endcase
    end

    // CPU read mux. A result read on an empty FIFO returns zero.
    always_comb begin
        rd_data_s = 16'h0000;
        if (rd_sel_s) begin
            rd_data_s = status_s;
        end else if (!res_empty_s) begin
            rd_data_s = res_mem_q[res_rp_q[RAW-1:0]];
        end else begin
            rd_data_s = 16'h0000;
        end
    end

    // Pointer and FSM registers. Reset flushes both FIFOs and drops any partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_wp_q <= '0;
            cmd_rp_q <= '0;
            res_wp_q <= '0;
            res_rp_q <= '0;
            state_q  <= ST_HDR;
            rem_q    <= 12'd0;
        end else begin
            cmd_wp_q <= cmd_wp_d;
            cmd_rp_q <= cmd_rp_d;
            res_wp_q <= res_wp_d;
            res_rp_q <= res_rp_d;
            state_q  <= state_d;
            rem_q    <= rem_d;
        end
    end

    // FIFO storage writes. The data arrays need no reset because the pointers gate every read.
    always_ff @(posedge clk) begin
        if (cmd_push_s) cmd_mem_q[cmd_wp_q[CAW-1:0]] <= bus.cpu_wr_data;
        if (res_push_s) res_mem_q[res_wp_q[RAW-1:0]] <= bus.res_data;
    end

`ifdef ACCEL_BUS_STATUS_EN
    // Sticky error flags. A status read clears them, but a set in the same cycle takes priority.
    always_comb begin
        ovf_d = (bus.cpu_wr_en & cmd_full_s) |
                (ovf_q & ~(bus.cpu_rd_en & rd_sel_s));
        unf_d = (bus.cpu_rd_en & ~rd_sel_s & res_empty_s) |
                (unf_q & ~(bus.cpu_rd_en & rd_sel_s));
    end

    // Sticky flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end
`endif

    assign bus.cpu_rd_data = rd_data_s;
    assign bus.cpu_busy    = cmd_full_s;
    assign bus.cmd_valid   = ~cmd_empty_s;
    assign bus.cmd_data    = cmd_empty_s ? 16'h0000 : cmd_head_s;
    assign bus.cmd_first   = cmd_first_s;
    assign bus.cmd_last    = cmd_last_s;
    assign bus.res_ready   = ~res_full_s;
endmodule

// File: tb/tb_accel_bus_port.sv
// tb_accel_bus_port: self-checking bench for accel_bus_port. Its reference model
// uses queues to hold FIFO contents and a count of payload words still owed to the
// current packet. The model is checked on every cycle, and directed checks use
// fixed literal values.
module tb_accel_bus_port;
    localparam int CMD_DEPTH = 8;
    localparam int RES_DEPTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accel_bus_port_if bus();

    accel_bus_port #(.CMD_DEPTH(CMD_DEPTH), .RES_DEPTH(RES_DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_cmd [$];
    logic [15:0] m_res [$];
    int          m_left;
    logic        m_ovf, m_unf;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic eff_sel();
`ifdef ACCEL_BUS_STATUS_EN
        return bus.cpu_rd_sel;
`else
        return 1'b0;
`endif
    endfunction

`ifdef ACCEL_BUS_STATUS_EN
    function automatic logic [3:0] msat(input int n);
        return (n > 15) ? 4'd15 : 4'(n);
    endfunction

    function automatic logic [15:0] m_status();
        return {m_cmd.size() == CMD_DEPTH, m_res.size() == 0, m_ovf, m_unf, 4'h0,
                msat(m_cmd.size()), msat(m_res.size())};
    endfunction
`endif

    task automatic set_in(input logic wr, input logic [15:0] wd, input logic rd,
                          input logic sel, input logic rdy, input logic rv,
                          input logic [15:0] rdat);
        bus.cpu_wr_en   = wr;
        bus.cpu_wr_data = wd;
        bus.cpu_rd_en   = rd;
        bus.cpu_rd_sel  = sel;
        bus.cmd_ready   = rdy;
        bus.res_valid   = rv;
        bus.res_data    = rdat;
    endtask

    // Let the combinational outputs settle, then compare every output with the model.
    task automatic settle();
        logic [15:0] hdr;
        logic [15:0] exp_rd;
        logic        exp_last;
        #3;
        chk1("cmd_valid", bus.cmd_valid, m_cmd.size() != 0);
        chk1("cpu_busy", bus.cpu_busy, m_cmd.size() == CMD_DEPTH);
        chk1("res_ready", bus.res_ready, m_res.size() != RES_DEPTH);
        if (m_cmd.size() != 0) begin
            hdr = m_cmd[0];
            exp_last = (m_left == 0) ? (hdr[11:0] == 12'd0) : (m_left == 1);
            chk16("cmd_data", bus.cmd_data, hdr);
            chk1("cmd_first", bus.cmd_first, m_left == 0);
            chk1("cmd_last", bus.cmd_last, exp_last);
        end
        exp_rd = (m_res.size() != 0) ? m_res[0] : 16'h0000;
`ifdef ACCEL_BUS_STATUS_EN
        if (bus.cpu_rd_sel) exp_rd = m_status();
`endif
        chk16("cpu_rd_data", bus.cpu_rd_data, exp_rd);
    endtask

    // Apply this cycle's inputs to the model, then move to one time unit after the next rising edge.
    task automatic adv();
        logic [15:0] hdr;
        logic        sel;
        int          csz, rsz;
        logic        status_rd, res_rd;
        sel       = eff_sel();
        csz       = m_cmd.size();
        rsz       = m_res.size();
        status_rd = bus.cpu_rd_en & sel;
        res_rd    = bus.cpu_rd_en & ~sel;
        if (csz > 0 && bus.cmd_ready) begin
            hdr = m_cmd.pop_front();
            if (m_left == 0) m_left = int'(hdr[11:0]);
            else             m_left = m_left - 1;
        end
        if (bus.cpu_wr_en && csz < CMD_DEPTH) m_cmd.push_back(bus.cpu_wr_data);
        if (res_rd && rsz > 0) void'(m_res.pop_front());
        if (bus.res_valid && rsz < RES_DEPTH) m_res.push_back(bus.res_data);
        m_ovf = (bus.cpu_wr_en && csz == CMD_DEPTH) | (m_ovf & ~status_rd);
        m_unf = (res_rd && rsz == 0) | (m_unf & ~status_rd);
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic wr, input logic [15:0] wd, input logic rd,
                       input logic sel, input logic rdy, input logic rv,
                       input logic [15:0] rdat);
        set_in(wr, wd, rd, sel, rdy, rv, rdat);
        settle();
        adv();
    endtask

    // Assert reset away from a clock edge, check the reset values, and clear the model.
    task automatic do_reset();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        rst_n = 1'b0;
        #2;
        chk1("rst cmd_valid", bus.cmd_valid, 1'b0);
        chk1("rst cmd_first", bus.cmd_first, 1'b1);
        chk1("rst cmd_last", bus.cmd_last, 1'b0);
        chk1("rst res_ready", bus.res_ready, 1'b1);
        chk1("rst cpu_busy", bus.cpu_busy, 1'b0);
        chk16("rst rd_data sel0", bus.cpu_rd_data, 16'h0000);
`ifdef ACCEL_BUS_STATUS_EN
        bus.cpu_rd_sel = 1'b1;
        #1;
        chk16("rst rd_data sel1", bus.cpu_rd_data, 16'h4000);
        bus.cpu_rd_sel = 1'b0;
`endif
        m_cmd.delete();
        m_res.delete();
        m_left = 0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] k;
        int wr_pct, rdy_pct, rv_pct, rd_pct;
        logic [15:0] wd;

        do_reset();

        // Three-word packet: header 3002 announces two payload words.
        cyc(1'b1, 16'h3002, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 16'hAAAA, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 16'hBBBB, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("p1 w0 first", bus.cmd_first, 1'b1);
        chk1("p1 w0 last", bus.cmd_last, 1'b0);
        chk16("p1 w0 data", bus.cmd_data, 16'h3002);
        adv();
        settle();
        chk1("p1 w1 first", bus.cmd_first, 1'b0);
        chk1("p1 w1 last", bus.cmd_last, 1'b0);
        chk16("p1 w1 data", bus.cmd_data, 16'hAAAA);
        adv();
        settle();
        chk1("p1 w2 first", bus.cmd_first, 1'b0);
        chk1("p1 w2 last", bus.cmd_last, 1'b1);
        chk16("p1 w2 data", bus.cmd_data, 16'hBBBB);
        adv();
        set_in(1'b1, 16'h5000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk1("p1 done valid", bus.cmd_valid, 1'b0);
        chk1("p1 done hdr", bus.cmd_first, 1'b1);
        adv();

        // Zero-length packet, followed by a one-payload packet.
        cyc(1'b1, 16'h1001, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("p0 first", bus.cmd_first, 1'b1);
        chk1("p0 last", bus.cmd_last, 1'b1);
        chk16("p0 data", bus.cmd_data, 16'h5000);
        adv();
        set_in(1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("p2 hdr first", bus.cmd_first, 1'b1);
        chk1("p2 hdr last", bus.cmd_last, 1'b0);
        adv();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("p2 pay first", bus.cmd_first, 1'b0);
        chk1("p2 pay last", bus.cmd_last, 1'b1);
        chk16("p2 pay data", bus.cmd_data, 16'hCAFE);
        adv();

        // Command overflow: nine writes against a stalled accelerator.
        for (int i = 0; i < 8; i++) begin
            k = 4'(i);
            cyc(1'b1, {k, 12'h000}, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        end
        set_in(1'b1, 16'h9000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk1("ovf busy", bus.cpu_busy, 1'b1);
        adv();
`ifdef ACCEL_BUS_STATUS_EN
        set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        settle();
        chk16("ovf status1", bus.cpu_rd_data, 16'hE080);
        adv();
        settle();
        chk16("ovf status2", bus.cpu_rd_data, 16'hC080);
        adv();
`endif
        for (int i = 0; i < 8; i++) begin
            k = 4'(i);
            set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
            settle();
            chk16("ovf drain", bus.cmd_data, {k, 12'h000});
            adv();
        end
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk1("ovf dropped", bus.cmd_valid, 1'b0);
        adv();

        // Result reads, ending with a read on an empty FIFO.
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0011);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0022);
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk16("res rd1", bus.cpu_rd_data, 16'h0011);
        adv();
        settle();
        chk16("res rd2", bus.cpu_rd_data, 16'h0022);
        adv();
        settle();
        chk16("res rd3 empty", bus.cpu_rd_data, 16'h0000);
        adv();
`ifdef ACCEL_BUS_STATUS_EN
        set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
        settle();
        chk16("unf status", bus.cpu_rd_data, 16'h5000);
        adv();
`endif

        // Result FIFO full: the ninth result word must be refused.
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0100 + 16'(i));
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 16'hDEAD);
        settle();
        chk1("res full ready", bus.res_ready, 1'b0);
        adv();
        set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk16("res full rd", bus.cpu_rd_data, 16'h0100);
        adv();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk1("res ready again", bus.res_ready, 1'b1);
        adv();
        for (int i = 1; i < 8; i++) begin
            set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
            settle();
            chk16("res drain", bus.cpu_rd_data, 16'h0100 + 16'(i));
            adv();
        end
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        settle();
        chk16("res 9th dropped", bus.cpu_rd_data, 16'h0000);
        adv();

        // Reset in the middle of a payload: the header has been taken and five words remain.
        cyc(1'b1, 16'h3005, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 16'h1111, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        cyc(1'b1, 16'h2222, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0077);
        cyc(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        do_reset();
        cyc(1'b1, 16'h2001, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        set_in(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("post-rst hdr first", bus.cmd_first, 1'b1);
        chk1("post-rst hdr last", bus.cmd_last, 1'b0);
        chk16("post-rst hdr data", bus.cmd_data, 16'h2001);
        adv();
        set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        settle();
        chk1("post-rst pay first", bus.cmd_first, 1'b0);
        chk1("post-rst pay last", bus.cmd_last, 1'b1);
        chk16("post-rst pay data", bus.cmd_data, 16'h1234);
        adv();

        // Random traffic in phases that alternately fill and drain each FIFO.
        for (int i = 0; i < 3000; i++) begin
            case ((i / 250) % 4)
                0:       begin wr_pct = 80; rdy_pct = 20; rv_pct = 30; rd_pct = 30; end
                1:       begin wr_pct = 30; rdy_pct = 90; rv_pct = 80; rd_pct = 15; end
                2:       begin wr_pct = 50; rdy_pct = 50; rv_pct = 20; rd_pct = 80; end
                default: begin wr_pct = 60; rdy_pct = 60; rv_pct = 50; rd_pct = 50; end
            endcase
            if (i == 1700) do_reset();
            if ($urandom_range(0, 3) == 0) wd = 16'($urandom);
            else wd = {4'($urandom), 8'h00, 4'($urandom_range(0, 3))};
            cyc($urandom_range(0, 99) < wr_pct, wd,
                $urandom_range(0, 99) < rd_pct, 1'($urandom),
                $urandom_range(0, 99) < rdy_pct,
                $urandom_range(0, 99) < rv_pct, 16'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
